ddr_line_adapter: RTL and testbench

- Sits directly downstream of the cache controller's memory port.
- Accepts one 256-bit line transfer (write-back or allocate) per request and splits it into DATA_BLOCKS-independent narrow beats on the DDR command/data interface.
- For reads, reassembles the returned beats into a full line.
- Signals completion with a one-cycle mem_ready pulse, which the controller uses to advance ALLOCATE / WRITE_BACK, including 1024-line flush sequences.

---
 rtl/ddr_line_adapter_if.sv | 37 +++
 rtl/ddr_line_adapter.sv | 121 ++++++++++++
 tb/tb_ddr_line_adapter.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_line_adapter_if.sv
// Cache-side line port and DDR-side beat port of the line adapter, bundled for port wiring.
// Handshakes: mem_valid is a level held until the one-cycle mem_ready pulse; a DDR beat
// transfers on a cycle with ddr_req && ddr_ack (req/addr/wdata held until then); ddr_rvalid
// returns read beats in issue order with no backpressure.
interface ddr_line_adapter_if #(
  parameter int ADDR_WIDTH = 28,
  parameter int LINE_WIDTH = 256,
  parameter int DDR_WIDTH  = 64
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [LINE_WIDTH-1:0] mem_wr;
  logic                  mem_rw;
  logic                  mem_valid;
  logic [LINE_WIDTH-1:0] mem_rd;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] ddr_addr;
  logic [DDR_WIDTH-1:0]  ddr_wdata;
  logic                  ddr_we;
  logic                  ddr_req;
  logic                  ddr_ack;
  logic [DDR_WIDTH-1:0]  ddr_rdata;
  logic                  ddr_rvalid;

  modport slave (
    input  mem_addr, mem_wr, mem_rw, mem_valid,
    output mem_rd, mem_ready,
    output ddr_addr, ddr_wdata, ddr_we, ddr_req,
    input  ddr_ack, ddr_rdata, ddr_rvalid
  );

  modport master (
    output mem_addr, mem_wr, mem_rw, mem_valid,
    input  mem_rd, mem_ready,
    input  ddr_addr, ddr_wdata, ddr_we, ddr_req,
    output ddr_ack, ddr_rdata, ddr_rvalid
  );
endinterface

// File: rtl/ddr_line_adapter.sv
// Splits one cache-line request into DDR-width beats and reassembles read beats into a line;
// completion is a single-cycle mem_ready pulse.
module ddr_line_adapter #(
  parameter int ADDR_WIDTH = 28,
  parameter int LINE_WIDTH = 256,
  parameter int DDR_WIDTH  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  ddr_line_adapter_if.slave    bus,
  output logic [1:0]           state_dbg
);
  localparam int BEATS          = LINE_WIDTH / DDR_WIDTH;
  localparam int WORDS_PER_BEAT = DDR_WIDTH / 32;
  localparam int CW             = $clog2(BEATS) + 1;
  localparam int IW             = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2, DONE = 2'd3} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cmd_cnt, rsp_cnt;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [DDR_WIDTH-1:0]  wbeat [BEATS];
  logic [DDR_WIDTH-1:0]  rbeat [BEATS];
  logic [LINE_WIDTH-1:0] mem_rd_q;
  logic [LINE_WIDTH-1:0] rd_line_next;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [IW-1:0]         cmd_idx, rsp_idx;
  logic                  req_c, we_c;
  logic                  cmd_fire, rsp_fire, last_cmd, last_rsp, accept;
  logic                  unused_addr_lsbs;

  // Line base is word-aligned to 8 words; the low address bits are don't-care.
  assign unused_addr_lsbs = ^bus.mem_addr[2:0];

  assign cmd_idx   = cmd_cnt[IW-1:0];
  assign rsp_idx   = rsp_cnt[IW-1:0];
  assign beat_addr = base_q + ADDR_WIDTH'(cmd_cnt) * ADDR_WIDTH'(WORDS_PER_BEAT);
  assign accept    = (state_q == IDLE) && bus.mem_valid;
  assign cmd_fire  = req_c && bus.ddr_ack;
  assign rsp_fire  = (state_q == READ) && bus.ddr_rvalid && (rsp_cnt < CW'(BEATS));
  assign last_cmd  = (cmd_cnt == CW'(BEATS - 1));
  assign last_rsp  = (rsp_cnt == CW'(BEATS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.mem_valid) state_d = bus.mem_rw ? WRITE : READ;
      WRITE: if (cmd_fire && last_cmd) state_d = DONE;
      READ:  if (rsp_fire && last_rsp) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_c         = 1'b0;
    we_c          = 1'b0;
    bus.ddr_addr  = '0;
    bus.ddr_wdata = '0;
    case (state_q)
      WRITE: begin
        req_c         = 1'b1;
        we_c          = 1'b1;
        bus.ddr_addr  = beat_addr;
        bus.ddr_wdata = wbeat[cmd_idx];
      end
      READ: begin
        if (cmd_cnt < CW'(BEATS)) begin
          req_c        = 1'b1;
          bus.ddr_addr = beat_addr;
        end
      end
      default: ;
    endcase
  end

  assign bus.ddr_req   = req_c;
  assign bus.ddr_we    = we_c;
  assign bus.mem_ready = (state_q == DONE);
  assign bus.mem_rd    = mem_rd_q;
  assign state_dbg     = state_q;

  // Line as it will look once the incoming beat lands; captured on the final response.
  always_comb begin
    rd_line_next = '0;
    for (int i = 0; i < BEATS; i++) begin
      rd_line_next[i*DDR_WIDTH +: DDR_WIDTH] = (rsp_idx == IW'(i)) ? bus.ddr_rdata : rbeat[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q   <= '0;
      cmd_cnt  <= '0;
      rsp_cnt  <= '0;
      mem_rd_q <= '0;
      for (int i = 0; i < BEATS; i++) begin
        wbeat[i] <= '0;
        rbeat[i] <= '0;
      end
    end else if (accept) begin
      base_q  <= {bus.mem_addr[ADDR_WIDTH-1:3], 3'b000};
      cmd_cnt <= '0;
      rsp_cnt <= '0;
      for (int i = 0; i < BEATS; i++) wbeat[i] <= bus.mem_wr[i*DDR_WIDTH +: DDR_WIDTH];
    end else begin
      if (cmd_fire) cmd_cnt <= cmd_cnt + CW'(1);
      if (rsp_fire) begin
        rbeat[rsp_idx] <= bus.ddr_rdata;
        rsp_cnt        <= rsp_cnt + CW'(1);
        if (last_rsp) mem_rd_q <= rd_line_next;
      end
    end
  end
endmodule

// File: tb/tb_ddr_line_adapter.sv
// Directed scoreboard bench for ddr_line_adapter: expected beats and completions are queued
// by the stimulus, and a negedge monitor checks them as the DUT presents them.
module tb_ddr_line_adapter;
  localparam int AW = 28;
  localparam int LW = 256;
  localparam int DW = 64;
  localparam int BEATS = LW / DW;
  localparam int BW = 1 + AW + DW;

  typedef struct {
    int          cyc;
    logic [LW-1:0] rd;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] state_dbg;
  int cycle_cnt = 0;
  int errors = 0;
  int checks = 0;
  logic stray_on = 1'b0;
  logic [LW-1:0] last_rd = '0;

  logic [BW-1:0] exp_q[$];
  rsp_t          exp_rsp_q[$];
  logic [DW-1:0] rd_src_q[$];

  ddr_line_adapter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .DDR_WIDTH(DW)) bus ();

  ddr_line_adapter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .DDR_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- helpers ----------------
  function automatic logic [LW-1:0] mk_line(input int seed);
    logic [LW-1:0] l;
    l = '0;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = 32'(seed + i + 1);
    return l;
  endfunction

  task automatic push_write(input logic [AW-1:0] base, input logic [LW-1:0] line);
    for (int j = 0; j < BEATS; j++) exp_q.push_back({1'b1, base + AW'(2*j), line[j*DW +: DW]});
  endtask

  task automatic push_read(input logic [AW-1:0] base);
    for (int j = 0; j < BEATS; j++) exp_q.push_back({1'b0, base + AW'(2*j), {DW{1'b0}}});
  endtask

  task automatic push_rsp(input int cyc, input logic [LW-1:0] rd);
    rsp_t r;
    r.cyc = cyc;
    r.rd  = rd;
    exp_rsp_q.push_back(r);
  endtask

  task automatic chk(input string nm, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_mem_ready"}, LW'(bus.mem_ready), '0);
    chk({nm, "_ddr_req"},   LW'(bus.ddr_req), '0);
    chk({nm, "_ddr_we"},    LW'(bus.ddr_we), '0);
    chk({nm, "_ddr_addr"},  LW'(bus.ddr_addr), '0);
    chk({nm, "_ddr_wdata"}, LW'(bus.ddr_wdata), '0);
    chk({nm, "_mem_rd"},    bus.mem_rd, '0);
    chk({nm, "_state"},     LW'(state_dbg), '0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_req(input logic [AW-1:0] addr, input logic [LW-1:0] line,
                        input logic rw, output int n);
    @(posedge clk);
    #1;
    bus.mem_addr  = addr;
    bus.mem_wr    = line;
    bus.mem_rw    = rw;
    bus.mem_valid = 1'b1;
    n = cycle_cnt;
  endtask

  // Returns at the negedge of the mem_ready cycle.
  task automatic wait_ready(input string nm, input int limit);
    logic found;
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.mem_ready) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no mem_ready within %0d cycles", nm, limit);
    end
  endtask

  // ---------------- DDR responder ----------------
  initial begin : responder
    logic fire;
    bus.ddr_rvalid = 1'b0;
    bus.ddr_rdata  = '0;
    forever begin
      @(negedge clk);
      fire = bus.ddr_req && bus.ddr_ack && !bus.ddr_we && !rst;
      @(posedge clk);
      #1;
      if (fire && rd_src_q.size() > 0) begin
        bus.ddr_rvalid = 1'b1;
        bus.ddr_rdata  = rd_src_q.pop_front();
      end else if (stray_on) begin
        bus.ddr_rvalid = 1'b1;
        bus.ddr_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
      end else begin
        bus.ddr_rvalid = 1'b0;
        bus.ddr_rdata  = '0;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin : monitor
    logic [BW-1:0] e;
    logic match;
    rsp_t r;
    if (!rst) begin
      if (bus.ddr_req) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: got we=%0b addr=%h wdata=%h, none expected",
                   bus.ddr_we, bus.ddr_addr, bus.ddr_wdata);
        end else begin
          e = exp_q[0];
          if (e[BW-1]) match = ({bus.ddr_we, bus.ddr_addr, bus.ddr_wdata} == e);
          else         match = ({bus.ddr_we, bus.ddr_addr} == e[BW-1:DW]);
          if (!match) begin
            errors++;
            $display("FAIL beat: got we=%0b addr=%h wdata=%h expected we=%0b addr=%h wdata=%h",
                     bus.ddr_we, bus.ddr_addr, bus.ddr_wdata, e[BW-1], e[DW +: AW], e[DW-1:0]);
          end
          if (bus.ddr_ack) void'(exp_q.pop_front());
        end
      end
      if (bus.mem_ready) begin
        checks++;
        if (exp_rsp_q.size() == 0) begin
          errors++;
          $display("FAIL ready_unexpected: mem_ready at cycle %0d, none expected", cycle_cnt);
        end else begin
          r = exp_rsp_q.pop_front();
          if (cycle_cnt != r.cyc || bus.mem_rd !== r.rd) begin
            errors++;
            $display("FAIL ready: got cycle %0d mem_rd %h expected cycle %0d mem_rd %h",
                     cycle_cnt, bus.mem_rd, r.cyc, r.rd);
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin : main
    int n;
    int stray_ready;
    logic [LW-1:0] line;
    logic [LW-1:0] fl [3];
    logic [AW-1:0] fa [3];
    logic [LW-1:0] rexp;

    rst           = 1'b1;
    bus.mem_addr  = '0;
    bus.mem_wr    = '0;
    bus.mem_rw    = 1'b0;
    bus.mem_valid = 1'b0;
    bus.ddr_ack   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;

    // Write line, zero-wait DDR
    line = 256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001;
    exp_q.push_back({1'b1, 28'h0001230, 64'h00000002_00000001});
    exp_q.push_back({1'b1, 28'h0001232, 64'h00000004_00000003});
    exp_q.push_back({1'b1, 28'h0001234, 64'h00000006_00000005});
    exp_q.push_back({1'b1, 28'h0001236, 64'h00000008_00000007});
    do_req(28'h0001235, line, 1'b1, n);
    push_rsp(n + 5, last_rd);
    wait_ready("write", 20);
    bus.mem_valid = 1'b0;

    // Read line, rvalid one cycle after each ack
    rexp = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
    rd_src_q.push_back(64'hA0);
    rd_src_q.push_back(64'hA1);
    rd_src_q.push_back(64'hA2);
    rd_src_q.push_back(64'hA3);
    push_read(28'h0000100);
    do_req(28'h0000100, '0, 1'b0, n);
    push_rsp(n + 6, rexp);
    wait_ready("read", 20);
    bus.mem_valid = 1'b0;
    last_rd = rexp;
    repeat (3) @(negedge clk);
    chk("read_hold", bus.mem_rd, 256'h00000000000000A3_00000000000000A2_00000000000000A1_00000000000000A0);

    // Backpressure: ack low for 3 cycles on beat 2
    line = mk_line(16);
    push_write(28'h0000400, line);
    do_req(28'h0000403, line, 1'b1, n);
    push_rsp(n + 8, last_rd);
    repeat (3) @(posedge clk);
    #1 bus.ddr_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.ddr_ack = 1'b1;
    wait_ready("stall", 30);
    bus.mem_valid = 1'b0;

    // Back-to-back flush of 3 lines with mem_valid held
    fa[0] = 28'h0002000; fl[0] = mk_line(32);
    fa[1] = 28'h000200D; fl[1] = mk_line(48);
    fa[2] = 28'hFFFFFFF; fl[2] = mk_line(64);
    push_write(28'h0002000, fl[0]);
    push_write(28'h0002008, fl[1]);
    push_write(28'hFFFFFF8, fl[2]);
    do_req(fa[0], fl[0], 1'b1, n);
    push_rsp(n + 5, last_rd);
    push_rsp(n + 11, last_rd);
    push_rsp(n + 17, last_rd);
    for (int k = 1; k < 3; k++) begin
      wait_ready("flush", 20);
      bus.mem_addr = fa[k];
      bus.mem_wr   = fl[k];
    end
    wait_ready("flush", 20);
    bus.mem_valid = 1'b0;

    // Write-back then allocate, stray rvalid during the write
    line = mk_line(80);
    rexp = {64'hC3, 64'hC2, 64'hC1, 64'hC0};
    push_write(28'h0003000, line);
    push_read(28'h0004000);
    rd_src_q.push_back(64'hC0);
    rd_src_q.push_back(64'hC1);
    rd_src_q.push_back(64'hC2);
    rd_src_q.push_back(64'hC3);
    do_req(28'h0003000, line, 1'b1, n);
    stray_on = 1'b1;
    push_rsp(n + 5, last_rd);
    push_rsp(n + 12, rexp);
    wait_ready("wb", 20);
    stray_on     = 1'b0;
    bus.mem_rw   = 1'b0;
    bus.mem_addr = 28'h0004000;
    wait_ready("alloc", 20);
    bus.mem_valid = 1'b0;
    last_rd = rexp;

    // Reset after 2 of 4 read responses
    rd_src_q.push_back(64'hD0);
    rd_src_q.push_back(64'hD1);
    rd_src_q.push_back(64'hD2);
    rd_src_q.push_back(64'hD3);
    push_read(28'h0005000);
    do_req(28'h0005000, '0, 1'b0, n);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1 check_idle("midreset");
    bus.mem_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rd_src_q.delete();
    exp_q.delete();
    rst = 1'b0;
    last_rd = '0;
    stray_ready = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.mem_ready) stray_ready++;
    end
    chk("no_ready_after_reset", LW'(stray_ready), '0);

    // Fresh read after reset
    rexp = {64'hE3, 64'hE2, 64'hE1, 64'hE0};
    rd_src_q.push_back(64'hE0);
    rd_src_q.push_back(64'hE1);
    rd_src_q.push_back(64'hE2);
    rd_src_q.push_back(64'hE3);
    push_read(28'h0006000);
    do_req(28'h0006000, '0, 1'b0, n);
    push_rsp(n + 6, rexp);
    wait_ready("fresh_read", 20);
    bus.mem_valid = 1'b0;

    repeat (5) @(negedge clk);
    chk("beats_left", LW'(exp_q.size()), '0);
    chk("readies_left", LW'(exp_rsp_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
